// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM read-side controllers: default widths and FSM states.
package ram_ctrl_pkg;

    localparam int unsigned RAM_ADDR_W = 5;
    localparam int unsigned RAM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] win_o
);

    // One-hot winner; a tie is resolved away from the previous owner
    always_comb begin
        win_o = '0;
        case (req_i)
            2'b01:   win_o = 2'b01;
            2'b10:   win_o = 2'b10;
            2'b11:   win_o = last_i ? 2'b01 : 2'b10;
            default: win_o = '0;
        endcase
    end

endmodule

// File: rtl/ram_rd_arb.sv
// Two-requester burst read arbiter in front of a single-port synchronous RAM.
// A granted requester gets L consecutive reads (len clamped to 2^ADDR_W) with
// wrapping addresses; read data is qualified per requester by rd_vld.
module ram_rd_arb
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] start_addr0,
    input  logic [ADDR_W-1:0] start_addr1,
    input  logic [ADDR_W:0]   len0,
    input  logic [ADDR_W:0]   len1,
    output logic [1:0]        gnt,
    output logic [1:0]        rd_vld,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        done,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data
);

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    rd_state_e         state_q;
    logic              last_q;
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   rem_q;
    logic [1:0]        gnt_q;
    logic [1:0]        rd_vld_q;
    logic [1:0]        done_q;
    logic              ram_rd_en_q;
    logic [ADDR_W-1:0] ram_rd_addr_q;

    logic [1:0]        win_d;
    logic              win_idx_d;
    logic [ADDR_W-1:0] sel_addr_d;
    logic [ADDR_W:0]   sel_len_raw_d;
    logic [ADDR_W:0]   sel_len_d;
    logic [1:0]        owner_oh_d;

    rr_arb2 u_rr_arb2 (
        .req_i  (req),
        .last_i (last_q),
        .win_o  (win_d)
    );

    // Winner's burst parameters, length clamped to the address space
    always_comb begin
        win_idx_d     = win_d[1];
        sel_addr_d    = win_idx_d ? start_addr1 : start_addr0;
        sel_len_raw_d = win_idx_d ? len1 : len0;
        sel_len_d     = (sel_len_raw_d > MAX_LEN) ? MAX_LEN : sel_len_raw_d;
        owner_oh_d    = {owner_q, ~owner_q};
    end

    // Burst FSM with registered outputs; rd_vld is ram_rd_en delayed one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            owner_q       <= 1'b0;
            addr_q        <= '0;
            rem_q         <= '0;
            gnt_q         <= '0;
            rd_vld_q      <= '0;
            done_q        <= '0;
            ram_rd_en_q   <= 1'b0;
            ram_rd_addr_q <= '0;
        end else begin
            gnt_q       <= '0;
            done_q      <= '0;
            ram_rd_en_q <= 1'b0;
            rd_vld_q    <= ram_rd_en_q ? owner_oh_d : 2'b00;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        gnt_q   <= win_d;
                        owner_q <= win_idx_d;
                        last_q  <= win_idx_d;
                        addr_q  <= sel_addr_d;
                        rem_q   <= sel_len_d;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    // Zero-length burst completes straight away with no RAM access
                    if (rem_q == '0) begin
                        done_q  <= owner_oh_d;
                        state_q <= IDLE;
                    end else begin
                        ram_rd_en_q   <= 1'b1;
                        ram_rd_addr_q <= addr_q;
                        addr_q        <= addr_q + 1'b1;
                        rem_q         <= rem_q - ONE;
                        if (rem_q == ONE) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Final read data returns now, so done lines up with the last rd_vld
                    done_q  <= owner_oh_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign rd_vld      = rd_vld_q;
    assign done        = done_q;
    assign ram_rd_en   = ram_rd_en_q;
    assign ram_rd_addr = ram_rd_addr_q;
    assign rd_data     = ram_rd_data;

endmodule

// File: tb/tb_ram_rd_arb.sv
// Bench for ram_rd_arb: transaction-level reference that schedules the expected
// per-cycle outputs of every grant, plus a RAM model preloaded with addr+8'h10.
module tb_ram_rd_arb;

    localparam int AW   = 5;
    localparam int DW   = 8;
    localparam int MAXC = 8192;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req = 2'b00;
    logic [AW-1:0] start_addr0 = '0;
    logic [AW-1:0] start_addr1 = '0;
    logic [AW:0]   len0 = '0;
    logic [AW:0]   len1 = '0;
    logic [1:0]    gnt, rd_vld, done;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] ram_rd_data = '0;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;

    logic [DW-1:0] mem [32];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int next_free = 0;
    int m_last = 1;
    int granted = -1;
    bit in_reset = 1'b0;
    bit hold = 1'b0;

    logic [1:0]    e_gnt  [MAXC];
    logic [1:0]    e_vld  [MAXC];
    logic [1:0]    e_done [MAXC];
    logic          e_en   [MAXC];
    logic [AW-1:0] e_addr [MAXC];
    logic [DW-1:0] e_data [MAXC];

    ram_rd_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .start_addr0 (start_addr0),
        .start_addr1 (start_addr1),
        .len0        (len0),
        .len1        (len1),
        .gnt         (gnt),
        .rd_vld      (rd_vld),
        .rd_data     (rd_data),
        .done        (done),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: data valid the cycle after the enable is sampled
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_from(input int c);
        for (int i = c; i < MAXC; i++) begin
            e_gnt[i] = '0; e_vld[i] = '0; e_done[i] = '0;
            e_en[i] = 1'b0; e_addr[i] = '0; e_data[i] = '0;
        end
    endtask

    // Decide what the coming edge grants and schedule the whole burst it implies
    task automatic model_edge();
        int e, w, l, s;
        e = cyc + 1;
        granted = -1;
        if (!in_reset && e >= next_free && req != 2'b00) begin
            if (req == 2'b11) w = 1 - m_last;
            else              w = req[1] ? 1 : 0;
            s = w ? int'(start_addr1) : int'(start_addr0);
            l = w ? int'(len1) : int'(len0);
            if (l > 32) l = 32;
            if (e + l + 2 < MAXC) begin
                e_gnt[e] = (w == 1) ? 2'b10 : 2'b01;
                for (int i = 0; i < l; i++) begin
                    e_en[e+1+i]   = 1'b1;
                    e_addr[e+1+i] = AW'((s + i) % 32);
                    e_vld[e+2+i]  = (w == 1) ? 2'b10 : 2'b01;
                    e_data[e+2+i] = mem[(s + i) % 32];
                end
                e_done[e+1+l] = (w == 1) ? 2'b10 : 2'b01;
            end
            next_free = e + l + 2;
            m_last = w;
            granted = w;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check("gnt", 32'(gnt), 32'(e_gnt[cyc]));
        check("ram_rd_en", 32'(ram_rd_en), 32'(e_en[cyc]));
        if (e_en[cyc]) check("ram_rd_addr", 32'(ram_rd_addr), 32'(e_addr[cyc]));
        check("rd_vld", 32'(rd_vld), 32'(e_vld[cyc]));
        check("done", 32'(done), 32'(e_done[cyc]));
        if (e_vld[cyc] != 2'b00) check("rd_data", 32'(rd_data), 32'(e_data[cyc]));
        if (granted >= 0 && !hold) req[granted] = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asynchronous reset: outputs must clear before any clock edge
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_vld", 32'(rd_vld), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_en", 32'(ram_rd_en), 32'd0);
        check("rst_addr", 32'(ram_rd_addr), 32'd0);
        in_reset = 1'b1;
        req = 2'b00;
        clear_from(cyc + 1);
        next_free = 0;
        m_last = 1;
        run(2);
        rst_n = 1'b1;
        in_reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = DW'(i + 16);
        clear_from(0);
        rst_n = 1'b1;
        #2;
        do_reset();

        // Single burst from requester 0
        start_addr0 = 5'd3; len0 = 6'd4; req = 2'b01;
        run(10);

        // Address wrap on requester 1
        start_addr1 = 5'd30; len1 = 6'd4; req = 2'b10;
        run(10);

        // Zero length, then over-long length clamped to 32 beats
        len0 = 6'd0; req = 2'b01;
        run(4);
        start_addr0 = 5'd7; len0 = 6'd40; req = 2'b01;
        run(40);

        // Both requests held from reset: alternating grants starting with 0
        do_reset();
        hold = 1'b1;
        start_addr0 = 5'd1; len0 = 6'd3; start_addr1 = 5'd20; len1 = 6'd2;
        req = 2'b11;
        run(20);
        hold = 1'b0;
        req = 2'b00;
        run(8);

        // Random traffic; inputs keep changing after grant and must not matter
        for (int i = 0; i < 400; i++) begin
            if (!req[0] && $urandom_range(0, 3) == 0) req[0] = 1'b1;
            if (!req[1] && $urandom_range(0, 3) == 0) req[1] = 1'b1;
            start_addr0 = AW'($urandom);
            start_addr1 = AW'($urandom);
            len0 = (AW+1)'($urandom_range(0, 40));
            len1 = (AW+1)'($urandom_range(0, 40));
            tick();
        end
        req = 2'b00;
        run(40);

        // Reset at the third beat of an 8-beat burst, then a tie goes to 0
        start_addr0 = 5'd10; len0 = 6'd8; req = 2'b01;
        run(4);
        check("mid_burst_en", 32'(ram_rd_en), 32'd1);
        #2;
        do_reset();
        start_addr0 = 5'd12; len0 = 6'd2; start_addr1 = 5'd5; len1 = 6'd2;
        req = 2'b11;
        tick();
        check("post_rst_gnt0", 32'(gnt), 32'd1);
        run(12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_rd_arb.md
RAM_RD_ARB -- requirements
Module: ram_rd_arb

Interface
REQ-001 Parameter ADDR_W, default 5, RAM address width (32 words).
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  2  per-requester burst request, level, held until gnt.
REQ-006 start_addr0 / start_addr1  input  ADDR_W each  first burst address per requester, sampled at grant.
REQ-007 len0 / len1  input  ADDR_W+1 each  burst length in words, sampled at grant.
REQ-008 gnt  output  2  one-cycle grant pulse per requester, registered.
REQ-009 rd_vld  output  2  per-requester read-data valid, registered.
REQ-010 rd_data  output  DATA_W  ram_rd_data passed through combinationally; qualify with rd_vld.
REQ-011 done  output  2  one-cycle burst-complete pulse per requester, registered.
REQ-012 ram_rd_en  output  1  RAM read enable, registered.
REQ-013 ram_rd_addr  output  ADDR_W  RAM read address, registered.
REQ-014 ram_rd_data  input  DATA_W  RAM read data, valid the cycle after ram_rd_en is sampled high.

Function
REQ-015 FSM states SHALL be IDLE, BURST, DRAIN.
REQ-016 IDLE: if any req bit set, SHALL at next edge pick a winner, latch its start address and length, pulse gnt[winner], enter BURST.
REQ-017 Arbitration SHALL be round-robin: on simultaneous requests the requester not granted last wins; after reset requester 0 wins.
REQ-018 BURST: ram_rd_en=1 for exactly L consecutive cycles, ram_rd_addr = start, start+1, ... modulo 2^ADDR_W (31 wraps to 0).
REQ-019 Effective length L SHALL be len clamped to 2^ADDR_W; len=0 SHALL give gnt and done in consecutive cycles with no RAM access and no rd_vld.
REQ-020 After the last BURST beat the FSM SHALL enter DRAIN for one cycle, then IDLE.
REQ-021 rd_vld[owner] SHALL equal ram_rd_en delayed one cycle; the other rd_vld bit SHALL stay 0.
REQ-022 done[owner] SHALL pulse in the same cycle as the final rd_vld[owner].
REQ-023 req changes during BURST/DRAIN SHALL be ignored; start_addr/len changes after grant SHALL not affect the burst.
REQ-024 Minimum gap between bursts SHALL be one IDLE cycle; ram_rd_en low in DRAIN and IDLE.
REQ-025 At most one gnt, rd_vld and done bit SHALL be high in any cycle.
REQ-026 Burst counter SHALL be ADDR_W+1 bits; address arithmetic SHALL be ADDR_W bits, natural wrap.

Reset
REQ-027 On rst_n low all outputs SHALL go 0 immediately: gnt, rd_vld, done, ram_rd_en = 0, ram_rd_addr = 0.
REQ-028 Reset SHALL force IDLE, clear counters, set round-robin pointer to favour requester 0.
REQ-029 Reset mid-burst SHALL abort with no done pulse; first edge after release evaluates req from IDLE.

Structure
REQ-030 State encoding and ADDR_W/DATA_W defaults SHALL live in shared package ram_ctrl_pkg.
REQ-031 Round-robin selection SHALL be a sub-module rr_arb2 (inputs req, last-owner; output one-hot winner).
REQ-032 Implementation SHALL be a single clock domain with no latches.

Verification
REQ-033 req=01, start_addr0=3, len0=4 -> gnt[0] 1 cycle; ram_rd_addr 3,4,5,6 with en; rd_vld[0] 4 cycles; done[0] with 4th.
REQ-034 req=11 held from reset -> grant order 0,1,0,1; one IDLE cycle between bursts; never two gnt bits high.
REQ-035 start_addr1=30, len1=4 -> ram_rd_addr 30,31,0,1; rd_data matches RAM preloaded addr+8'h10.
REQ-036 len0=0 -> gnt[0] then done[0] next cycle; ram_rd_en stays 0; len0=40 -> 32 beats.
REQ-037 rst_n low at 3rd beat of 8-beat burst -> all outputs 0 asynchronously; no done; next grant to requester 0.
